// File: rtl/aes_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers, key schedule steps and FSM states.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_ADDK,
    S_ROUND,
    S_FINAL,
    S_DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0,4'he)^gf_mul(a1,4'hb)^gf_mul(a2,4'hd)^gf_mul(a3,4'h9),
            gf_mul(a0,4'h9)^gf_mul(a1,4'he)^gf_mul(a2,4'hb)^gf_mul(a3,4'hd),
            gf_mul(a0,4'hd)^gf_mul(a1,4'h9)^gf_mul(a2,4'he)^gf_mul(a3,4'hb),
            gf_mul(a0,4'hb)^gf_mul(a1,4'hd)^gf_mul(a2,4'h9)^gf_mul(a3,4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
            inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
  endfunction

  // byte (row r, col c) lives at index 4c+r, msb first
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = rk[31:0] ^ rk[63:32];
    n2 = rk[63:32] ^ rk[95:64];
    n1 = rk[95:64] ^ rk[127:96];
    n0 = rk[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse cipher round plus the matching backward key step.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk_in,
  input  logic [7:0]   rc,
  input  logic         last,
  output logic [127:0] st_next,
  output logic [127:0] rk_prev
);

  logic [127:0] keyed;

  always_comb begin
    rk_prev = inv_expand(rk_in, rc);
    keyed   = inv_sub_bytes(inv_shift_rows(st)) ^ rk_prev;
    st_next = last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 decryptor, one round per clock.
// Round keys are unrolled backward from a cached k10.
module aes128_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key,
  input  logic         new_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_decrypt_core: only NR=10 is supported");
  end

  aes_state_e   state_q, state_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] k10_q, k10_d;
  logic [127:0] plain_out_q, plain_out_d;
  logic         cache_valid_q, cache_valid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;

  logic [127:0] rnd_st, rnd_rk;
  logic [7:0]   rnd_rc;
  logic         rnd_last;
  logic         expand;

  assign rnd_rc   = rcon(ctr_q + 4'd1);
  assign rnd_last = (state_q == S_FINAL);
  assign expand   = new_key | ~cache_valid_q | ~KEY_CACHE;

  aes_inv_round u_round (
    .st      (st_q),
    .rk_in   (rk_q),
    .rc      (rnd_rc),
    .last    (rnd_last),
    .st_next (rnd_st),
    .rk_prev (rnd_rk)
  );

  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    st_d          = st_q;
    rk_d          = rk_q;
    k10_d         = k10_q;
    plain_out_d   = plain_out_q;
    cache_valid_d = cache_valid_q;
    out_valid_d   = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d = cipher_in;
          if (expand) begin
            rk_d    = key;
            ctr_d   = 4'd1;
            state_d = S_KEYEXP;
          end else begin
            rk_d    = k10_q;
            state_d = S_ADDK;
          end
        end
      end
      S_KEYEXP: begin
        rk_d  = fwd_expand(rk_q, rcon(ctr_q));
        ctr_d = ctr_q + 4'd1;
        if (ctr_q == 4'd10) begin
          k10_d         = rk_d;
          cache_valid_d = 1'b1;
          state_d       = S_ADDK;
        end
      end
      S_ADDK: begin
        st_d    = st_q ^ rk_q;
        ctr_d   = 4'd9;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        st_d  = rnd_st;
        rk_d  = rnd_rk;
        ctr_d = ctr_q - 4'd1;
        if (ctr_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        st_d        = rnd_st;
        rk_d        = rnd_rk;
        plain_out_d = rnd_st;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ctr_q         <= '0;
      st_q          <= '0;
      rk_q          <= '0;
      k10_q         <= '0;
      plain_out_q   <= '0;
      cache_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      st_q          <= st_d;
      rk_q          <= rk_d;
      k10_q         <= k10_d;
      plain_out_q   <= plain_out_d;
      cache_valid_q <= cache_valid_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plain_out = plain_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Scoreboard bench for aes128_decrypt_core with an independent
// AES-128 encryptor (S-box derived from GF(2^8) inversion).
module tb_aes128_decrypt_core;

  localparam logic [127:0] C1_K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_K    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         new_key = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] cipher_in = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] plain_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;
  bit ov_seen = 1'b0;
  bit cv_m = 1'b0;
  logic [127:0] ck_m = '0;
  logic [7:0] sbx [256];

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  aes128_decrypt_core #(.NR(10), .KEY_CACHE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .key       (key),
    .new_key   (new_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, t, rk;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  w;
    rk = k;
    s  = pt ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbx[s[127-8*i -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[127-8*(4*c+j) -: 8] = t[127-8*(4*((c+j)%4)+j) -: 8];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {gm(a0,2)^gm(a1,3)^a2^a3, a0^gm(a1,2)^gm(a2,3)^a3,
                               a0^a1^gm(a2,2)^gm(a3,3), gm(a0,3)^a1^a2^gm(a3,2)};
        end
      end
      w = {rk[23:0], rk[31:24]};
      w = {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]} ^ {rc, 24'h0};
      rk[127:96] = rk[127:96] ^ w;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      s  = s ^ rk;
      rc = gm(rc, 8'h02);
    end
    return s;
  endfunction

  // Scoreboard side: pop on each rising out_valid
  always @(negedge clk) begin
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    if (rst) ov_seen = 1'b0;
    else if (out_valid && !ov_seen) begin
      ov_seen = 1'b1;
      if (sb_q.size() == 0) check("sb_empty", 128'd1, 128'd0);
      else begin
        mon_e = sb_q.pop_front();
        check("pt", plain_out, mon_e.pt);
        check("lat", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
      end
    end else if (!out_valid) ov_seen = 1'b0;
  end

  task automatic send(input logic [127:0] ct, input logic [127:0] k,
                      input logic nk, input logic [127:0] pt);
    exp_t e;
    int   n;
    bit   ex;
    n  = 0;
    ex = nk || !cv_m;
    cipher_in = ct;
    key       = k;
    new_key   = nk;
    in_valid  = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_to", 128'd0, 128'd1);
      in_valid = 1'b0;
      return;
    end
    e.pt  = pt;
    e.lat = ex ? 21 : 11;
    e.acc = cyc + 1;
    sb_q.push_back(e);
    if (ex) begin
      cv_m = 1'b1;
      ck_m = k;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && sb_q.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_to", 128'd0, 128'd1);
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("ov_to", 128'd0, 128'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt, k, hold;
    logic         nk;
    for (int i = 0; i < 256; i++) sbx[i] = sbox_calc(8'(i));

    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_plain", plain_out, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 128'(in_ready), 128'd1);

    // cold cache with new_key=0 must still expand
    send(C1_CT, C1_K, 1'b0, C1_PT);
    wait_idle();

    send(C1_CT, C1_K, 1'b1, C1_PT);
    wait_ov();
    @(negedge clk);
    check("done_1cyc", 128'(out_valid), 128'd0);
    check("ready_back", 128'(in_ready), 128'd1);
    check("pout_hold", plain_out, C1_PT);
    check("k10_c1", dut.k10_q, C1_K10);

    send(B_CT, B_K, 1'b1, B_PT);
    wait_idle();
    check("k10_b", dut.k10_q, B_K10);
    send(B_CT, B_K, 1'b0, B_PT);
    wait_idle();

    // back-pressure; key input is junk and must be ignored
    out_ready = 1'b0;
    send(B_CT, 128'h0, 1'b0, B_PT);
    wait_ov();
    hold = plain_out;
    for (int i = 0; i < 5; i++) begin
      check("bp_pt", plain_out, B_PT);
      check("bp_ov", 128'(out_valid), 128'd1);
      check("bp_ready", 128'(in_ready), 128'd0);
      in_valid  = 1'(i % 2);
      new_key   = 1'b1;
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ov", 128'(out_valid), 128'd0);
    check("bp_hold", plain_out, hold);
    repeat (3) @(negedge clk);
    check("bp_no_start", 128'(busy), 128'd0);

    // reset in the middle of key expansion
    send(C1_CT, C1_K, 1'b1, C1_PT);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ov", 128'(out_valid), 128'd0);
    check("mid_rst_plain", plain_out, 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_ready", 128'(in_ready), 128'd0);
    sb_q.delete();
    cv_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_back", 128'(in_ready), 128'd1);
    send(C1_CT, C1_K, 1'b0, C1_PT);
    wait_idle();

    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      nk = 1'($urandom_range(0, 1));
      send(enc(pt, (nk || !cv_m) ? k : ck_m), k, nk, pt);
    end
    wait_idle();
    rdy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
